// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// address-width computation and the flat-bus port slicing helper.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   // Address width for a register file of n entries (never below 1 bit).
   function automatic int calc_aw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Low bit index of port p on a flat bus whose ports are width bits wide.
   function automatic int slice_lo(input int p, input int width);
      return p * width;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// count of busy registers. Alloc sets, write-back clears, alloc wins a tie.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int NWR      = 1,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW      = calc_aw(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_en,
   input  logic [AW-1:0]     alloc_addr,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   output logic [NREGS-1:0]  busy,
   output logic [AW:0]       pend_cnt
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [NREGS-1:0] set_mask, clr_mask;
   logic [AW:0]      pend_cnt_q, pend_cnt_d;
   logic [AW:0]      n_clr;
   logic             inc;

   // Decode alloc and write-back strobes into per-register set/clear masks.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (alloc_en) set_mask[alloc_addr] = 1'b1;
      for (int w = 0; w < NWR; w++) begin
         if (wr_en[w]) clr_mask[wr_addr[slice_lo(w, AW) +: AW]] = 1'b1;
      end
      if (ZERO_REG) begin
         set_mask[0] = 1'b0;
         clr_mask[0] = 1'b0;
      end
   end

   // Next busy vector and incremental count; duplicate clears collapse in the
   // mask, and a bit re-set by alloc this edge is not counted as cleared.
   always_comb begin
      n_clr = '0;
      for (int r = 0; r < NREGS; r++) begin
         if (clr_mask[r] && busy_q[r] && !set_mask[r]) n_clr = n_clr + (AW+1)'(1);
      end
      inc        = |(set_mask & ~busy_q);
      busy_d     = (busy_q & ~clr_mask) | set_mask;
      pend_cnt_d = pend_cnt_q + (AW+1)'(inc) - n_clr;
   end

   // Busy bits and count, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign busy     = busy_q;
   assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: data array, write-port arbitration,
// combinational read ports with optional write-to-read bypass, and the
// pending-write scoreboard feeding the hazard unit.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW      = calc_aw(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   output logic [AW:0]         pend_cnt
);

   logic [XLEN-1:0]  data_q [NREGS];
   logic [XLEN-1:0]  data_d [NREGS];
   logic [NREGS-1:0] busy;
   logic [AW-1:0]    ra  [NRD];
   logic [XLEN-1:0]  fwd [NRD];
   logic [NRD-1:0]   hit;

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .busy       (busy),
      .pend_cnt   (pend_cnt)
   );

   // Array next state; ports applied in ascending order so the highest index wins.
   always_comb begin
      for (int r = 0; r < NREGS; r++) data_d[r] = data_q[r];
      for (int w = 0; w < NWR; w++) begin
         if (wr_en[w] && (!ZERO_REG || wr_addr[slice_lo(w, AW) +: AW] != '0))
            data_d[wr_addr[slice_lo(w, AW) +: AW]] = wr_data[slice_lo(w, XLEN) +: XLEN];
      end
   end

   // Data array, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) data_q[r] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) data_q[r] <= data_d[r];
      end
   end

   // Read ports: zero register and reset force 0, else bypass or array data;
   // a forwarded write also hides the busy bit it is about to clear.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int p = 0; p < NRD; p++) begin
         ra[p]  = rd_addr[slice_lo(p, AW) +: AW];
         hit[p] = 1'b0;
         fwd[p] = data_q[ra[p]];
         if (BYPASS) begin
            for (int w = 0; w < NWR; w++) begin
               if (wr_en[w] && wr_addr[slice_lo(w, AW) +: AW] == ra[p]) begin
                  hit[p] = 1'b1;
                  fwd[p] = wr_data[slice_lo(w, XLEN) +: XLEN];
               end
            end
         end
         if (rst || (ZERO_REG && ra[p] == '0)) begin
            rd_data[slice_lo(p, XLEN) +: XLEN] = '0;
            rd_busy[p]                         = 1'b0;
         end else begin
            rd_data[slice_lo(p, XLEN) +: XLEN] = fwd[p];
            rd_busy[p]                         = busy[ra[p]] & ~hit[p];
         end
      end
   end

endmodule
